// File: rtl/lut_pkg.sv
// Shared types and reset contents for the immediate/address LUT.
// The forward LUT and the reverse-search register copy both load LUT_RESET_TABLE.
package lut_pkg;

    localparam int LUT_DEPTH = 32;
    localparam int LUT_DW    = 8;
    localparam int LUT_IW    = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} lut_state_t;

    localparam logic [LUT_DW-1:0] LUT_RESET_TABLE [LUT_DEPTH] = '{
        0: 8'hF5, 1: 8'h09, 2: 8'hEC, 3: 8'h0E, 4: 8'h03, 5: 8'h11,
        default: 8'h00
    };

endpackage

// File: rtl/lut_rev_search_if.sv
// Table-write, request and response bundle of the LUT reverse search.
// The master is the loader/assembler side; the slave is lut_rev_search.
interface lut_rev_search_if #(
    parameter int DW = 8,
    parameter int IW = 5
) ();

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_val;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_hit;
    logic [IW-1:0] rsp_idx;
    logic          busy;

    modport master (
        output wr_en, wr_idx, wr_data, req_valid, req_val, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_idx, busy
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, req_valid, req_val, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_idx, busy
    );

endinterface

// File: rtl/lut_reg_file.sv
// DEPTH x DW writable copy of the LUT: synchronous write, combinational read,
// synchronous reset back to the forward-LUT contents.
module lut_reg_file
    import lut_pkg::*;
#(
    parameter int DEPTH = LUT_DEPTH,
    parameter int DW    = LUT_DW,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    function automatic logic [DW-1:0] reset_entry(input int i);
        logic [LUT_IW-1:0] ri;
        ri = i[LUT_IW-1:0];
        return (i < LUT_DEPTH) ? DW'(LUT_RESET_TABLE[ri]) : '0;
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_idx] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= reset_entry(i);
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write is not compared.
    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/lut_rev_search.sv
// Reverse LUT lookup: scans one entry per cycle for the lowest index holding the key.
//   state | meaning
//   IDLE  | ready for a request; key latched on req_valid
//   SCAN  | comparing table[cnt] with the key, cnt counting up from 0
//   RESP  | result presented, held until rsp_ready
module lut_rev_search
    import lut_pkg::*;
#(
    parameter int DEPTH = LUT_DEPTH,
    parameter int DW    = LUT_DW,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    lut_rev_search_if.slave  bus
);

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    lut_state_t    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] key_q, key_d;
    logic          hit_q, hit_d;
    logic [DW-1:0] rd_data;

    lut_reg_file #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_idx  (bus.wr_idx),
        .wr_data (bus.wr_data),
        .rd_idx  (cnt_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        key_d   = key_q;
        hit_d   = hit_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    key_d   = bus.req_val;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (rd_data == key_q) begin
                    hit_d   = 1'b1;
                    idx_d   = cnt_q;
                    state_d = RESP;
                end else if (cnt_q == LAST_IDX) begin
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            key_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_hit   = hit_q;
    assign bus.rsp_idx   = idx_q;

endmodule
